// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer paced by ticks from an asynchronous slow clock,
// with a latched pedestrian request that is served by a walk phase during RED.
module traffic_light_ctrl #(
  parameter int unsigned RED_TICKS       = 8,
  parameter int unsigned RED_AMBER_TICKS = 2,
  parameter int unsigned GREEN_TICKS     = 12,
  parameter int unsigned AMBER_TICKS     = 3,
  parameter int unsigned MIN_GREEN_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       ped_req,
  output logic       red,
  output logic       amber,
  output logic       green,
  output logic       walk,
  output logic       ped_wait,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RED       = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } state_t;

  // Last tick_cnt value of each state: the state ends on the tick seen there.
  localparam logic [7:0] RED_LAST       = 8'(RED_TICKS - 1);
  localparam logic [7:0] RED_AMBER_LAST = 8'(RED_AMBER_TICKS - 1);
  localparam logic [7:0] GREEN_LAST     = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] AMBER_LAST     = 8'(AMBER_TICKS - 1);
  localparam logic [7:0] MIN_GREEN_LAST = 8'(MIN_GREEN_TICKS - 1);

  logic [1:0] async_in;
  logic [1:0] rise;
  logic       slow_rise;
  logic       ped_rise;

  assign async_in  = {ped_req, slow_clk};
  assign slow_rise = rise[0];
  assign ped_rise  = rise[1];

  // Both asynchronous inputs get a 2-flop synchronizer plus a history flop.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign rise[gi] = sync_reg & ~prev_reg;
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [7:0] tick_cnt_reg, tick_cnt_next;
  logic       tick_reg;
  logic       ped_pending_reg, ped_pending_next;
  logic       walk_phase_reg, walk_phase_next;
  logic       red_reg, red_next;
  logic       amber_reg, amber_next;
  logic       green_reg, green_next;
  logic       walk_reg, walk_next;
  logic       dwell_done;
  logic       advance;

  always_comb begin
    state_next       = state_reg;
    tick_cnt_next    = tick_cnt_reg;
    ped_pending_next = ped_pending_reg;
    walk_phase_next  = walk_phase_reg;
    dwell_done       = 1'b0;

    case (state_reg)
      RED:       dwell_done = (tick_cnt_reg == RED_LAST);
      RED_AMBER: dwell_done = (tick_cnt_reg == RED_AMBER_LAST);
      // Early exit looks only at the registered request, never a same-cycle edge.
      GREEN:     dwell_done = (tick_cnt_reg == GREEN_LAST) ||
                              (ped_pending_reg && (tick_cnt_reg >= MIN_GREEN_LAST));
      AMBER:     dwell_done = (tick_cnt_reg == AMBER_LAST);
      default:   dwell_done = 1'b0;
    endcase

    advance = tick_reg && dwell_done;

    if (tick_reg) begin
      if (dwell_done) begin
        tick_cnt_next = 8'd0;
        case (state_reg)
          RED:       state_next = RED_AMBER;
          RED_AMBER: state_next = GREEN;
          GREEN:     state_next = AMBER;
          AMBER:     state_next = RED;
          default:   state_next = RED;
        endcase
      end else begin
        tick_cnt_next = tick_cnt_reg + 8'd1;
      end
    end

    if (ped_rise) begin
      ped_pending_next = 1'b1;
    end

    // Entering RED serves everything pending, including an edge on this very cycle.
    if (advance && (state_reg == AMBER)) begin
      walk_phase_next  = ped_pending_reg | ped_rise;
      ped_pending_next = 1'b0;
    end

    if (advance && (state_reg == RED)) begin
      walk_phase_next = 1'b0;
    end

    red_next   = (state_next == RED) || (state_next == RED_AMBER);
    amber_next = (state_next == RED_AMBER) || (state_next == AMBER);
    green_next = (state_next == GREEN);
    walk_next  = walk_phase_next && (state_next == RED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RED;
      tick_cnt_reg    <= 8'd0;
      tick_reg        <= 1'b0;
      ped_pending_reg <= 1'b0;
      walk_phase_reg  <= 1'b0;
      red_reg         <= 1'b1;
      amber_reg       <= 1'b0;
      green_reg       <= 1'b0;
      walk_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tick_cnt_reg    <= tick_cnt_next;
      tick_reg        <= slow_rise;
      ped_pending_reg <= ped_pending_next;
      walk_phase_reg  <= walk_phase_next;
      red_reg         <= red_next;
      amber_reg       <= amber_next;
      green_reg       <= green_next;
      walk_reg        <= walk_next;
    end
  end

  assign red      = red_reg;
  assign amber    = amber_reg;
  assign green    = green_reg;
  assign walk     = walk_reg;
  assign ped_wait = ped_pending_reg;
  assign state    = state_reg;

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- RED_TICKS, 8, ticks spent in RED.
- RED_AMBER_TICKS, 2, ticks spent in RED_AMBER.
- GREEN_TICKS, 12, maximum ticks spent in GREEN.
- AMBER_TICKS, 3, ticks spent in AMBER.
- MIN_GREEN_TICKS, 4, minimum GREEN ticks before a pedestrian request may end GREEN.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, input, 1, system clock (50 MHz); one clock only.
- reset, input, 1, asynchronous, active-high reset.
- slow_clk, input, 1, slow square wave from the upstream clock divider; asynchronous to clk.
- ped_req, input, 1, pedestrian push-button level; asynchronous to clk.
- red, output, 1, red lamp.
- amber, output, 1, amber lamp.
- green, output, 1, green lamp.
- walk, output, 1, pedestrian walk lamp.
- ped_wait, output, 1, request-pending indicator.
- state, output, 2, encoded current state.

REQ-003 Parameter values SHALL lie in the range 1..255, and MIN_GREEN_TICKS SHALL NOT exceed GREEN_TICKS; other values are unsupported.

Function
REQ-004 slow_clk SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector, producing an internal tick.
- tick is high for exactly one clk cycle per slow_clk rising edge, at the 3rd clk edge after slow_clk is first sampled high.
- A slow_clk held high produces no further ticks.

REQ-005 ped_req SHALL be synchronized with its own 2-flop synchronizer; only its rising edge sets ped_pending.
- Holding ped_req high SHALL register one request only.

REQ-006 The state machine SHALL have four states with this encoding: RED=0, RED_AMBER=1, GREEN=2, AMBER=3.
- The sequence is RED->RED_AMBER->GREEN->AMBER->RED.
- No other transitions exist; unused encodings do not occur.

REQ-007 An 8-bit tick_cnt SHALL count ticks within the current state.
- It increments only on tick.
- It clears to 0 on every state transition.
- It never wraps, because every duration is ≤255.

REQ-008 In RED, RED_AMBER and AMBER, the state SHALL advance on the tick where tick_cnt == DUR-1, DUR being that state's duration parameter.

REQ-009 GREEN SHALL advance to AMBER on the tick where either condition holds:
- tick_cnt == GREEN_TICKS-1; or
- ped_pending==1 and tick_cnt >= MIN_GREEN_TICKS-1.

REQ-010 State transitions SHALL occur on the clk edge at which tick is high, i.e. 1 clk after the tick is generated.
- All outputs SHALL be registered and SHALL update on that same edge.

REQ-011 Lamp decoding SHALL be:
- RED: red=1.
- RED_AMBER: red=1, amber=1.
- GREEN: green=1.
- AMBER: amber=1.
- All unlisted lamps are 0.

REQ-012 On the AMBER->RED transition, ped_pending SHALL be copied into a walk_phase flag, and ped_pending SHALL clear.
- walk = walk_phase AND (state==RED), for the whole RED duration.
- walk_phase clears on RED->RED_AMBER.

REQ-013 A ped_req edge arriving on the same cycle as the AMBER->RED transition SHALL be served by that RED phase: walk_phase=1 and ped_pending=0.

REQ-014 A ped_req edge arriving in any other state, including RED with walk active, SHALL set ped_pending, which then holds until the next AMBER->RED transition.

REQ-015 ped_wait SHALL equal ped_pending.

REQ-016 A tick and a ped_req edge in the same cycle while in GREEN SHALL NOT cause early exit on that tick.
- REQ-009 evaluates the registered ped_pending.

Reset
REQ-017 Asserting reset SHALL immediately, without waiting for clk, force:
- state=RED and tick_cnt=0;
- red=1, amber=0, green=0, walk=0;
- ped_pending=0 and ped_wait=0;
- walk_phase=0;
- all synchronizer and edge-detect flops to 0.

REQ-018 Assertion of reset SHALL take effect identically mid-sequence.
- The first tick after deassertion counts as tick 1 of RED.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (default parameters):
- Reset, 8 ticks, no ped_req -> RED for 8 ticks, then RED_AMBER (red=1, amber=1) for 2, GREEN for 12, AMBER for 3, back to RED; full cycle 25 ticks, walk=0 throughout.
- slow_clk rises at clk edge n and stays high 1000 cycles -> one tick, state/outputs change at edge n+3 only.
- ped_req pulse (5 cycles) in GREEN at tick_cnt=0 -> ped_wait=1 next cycles; GREEN ends on 4th tick; AMBER 3 ticks; RED with walk=1 for all 8 ticks and ped_wait=0.
- ped_req edge on the exact AMBER->RED cycle -> walk=1 during that RED, ped_wait stays 0.
- ped_req held high from reset for 3 full cycles -> exactly one walk phase (first RED after first AMBER), later REDs walk=0.
- reset asserted mid-GREEN at tick_cnt=6 with ped_pending=1 -> same cycle red=1, green=0, ped_wait=0; after release, 8 ticks to RED_AMBER.
